// File: rtl/dfc_rx_fifo_if.sv
// dfc_rx_fifo_if
//   Bundles the two sides of the DFC receive FIFO: the delayed-flow-control
//   link (c_*) from the remote sender and the srdy/drdy consumer side (p_*).
// Signals
//   c_vld   link word valid, no per-word handshake
//   c_data  link word
//   c_fc_n  flow control back to the sender, 1 = may send, 0 = stop
//   p_srdy  FIFO not empty, p_data valid
//   p_drdy  consumer accepts the head word this cycle
//   p_data  word at the FIFO head
// Modports
//   master  environment side: drives the link word and p_drdy
//   slave   FIFO side: drives c_fc_n, p_srdy and p_data
interface dfc_rx_fifo_if #(
    parameter int width = 8
);
    logic             c_vld;
    logic [width-1:0] c_data;
    logic             c_fc_n;
    logic             p_srdy;
    logic             p_drdy;
    logic [width-1:0] p_data;

    modport master (
        output c_vld, c_data, p_drdy,
        input  c_fc_n, p_srdy, p_data
    );

    modport slave (
        input  c_vld, c_data, p_drdy,
        output c_fc_n, p_srdy, p_data
    );
endinterface

// File: rtl/dfc_rx_fifo.sv
// dfc_rx_fifo
//   Receive end of a delayed-flow-control link. Every word presented with
//   c_vld is captured into a circular FIFO and re-issued on the srdy/drdy
//   side in strict arrival order. A registered active-low flow-control
//   output throttles the sender; depth - threshold must cover the full
//   round trip of the flow-control loop so in-flight words always fit.
// Ports
//   clk     clock, all logic on the rising edge
//   reset   synchronous, active-high; empties the FIFO, c_fc_n goes low
//   link    dfc_rx_fifo_if.slave (c_vld, c_data, c_fc_n, p_srdy, p_drdy, p_data)
// Parameters
//   width      data word width
//   depth      number of entries (>= 2, need not be a power of two)
//   threshold  fill level above which c_fc_n is driven low
module dfc_rx_fifo #(
    parameter int width     = 8,
    parameter int depth     = 8,
    parameter int threshold = 1
) (
    input  logic          clk,
    input  logic          reset,
    dfc_rx_fifo_if.slave  link
);
    localparam int ptr_w = $clog2(depth);
    localparam int cnt_w = $clog2(depth + 1);
    localparam logic [cnt_w-1:0] depth_c = cnt_w'(depth);
    localparam logic [cnt_w-1:0] thr_c   = cnt_w'(threshold);
    localparam logic [ptr_w-1:0] last_c  = ptr_w'(depth - 1);

    logic [width-1:0] mem [depth];
    logic [ptr_w-1:0] rd_ptr;
    logic [ptr_w-1:0] wr_ptr;
    logic [cnt_w-1:0] count;
    logic [cnt_w-1:0] count_next;
    logic             fc_n;
    logic             rd;
    logic             wr;

    // Pointers wrap explicitly so depth need not be a power of two.
    function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] p);
        return (p == last_c) ? '0 : p + ptr_w'(1);
    endfunction

    assign link.p_srdy = (count != '0);
    assign link.p_data = mem[rd_ptr];
    assign link.c_fc_n = fc_n;

    // A simultaneous read frees a slot, so a full FIFO still accepts a word
    // in the same cycle its head is consumed.
    assign rd = link.p_srdy & link.p_drdy;
    assign wr = link.c_vld & ((count < depth_c) | rd);

    always_comb begin
        count_next = count;
        if (wr && !rd) begin
            count_next = count + cnt_w'(1);
        end else if (rd && !wr) begin
            count_next = count - cnt_w'(1);
        end
    end

    // Flow control is computed from the next fill level so the sender sees
    // the stop one cycle earlier than it would from the registered count.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            fc_n   <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (rd) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count_next;
            fc_n  <= (count_next <= thr_c);
        end
    end

    // Storage is deliberately not reset; emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (wr && !reset) begin
            mem[wr_ptr] <= link.c_data;
        end
    end
endmodule

// File: tb/tb_dfc_rx_fifo.sv
// tb_dfc_rx_fifo
//   Directed bench for dfc_rx_fifo (width 8, depth 8, threshold 1): reset
//   values, single-word latency, fill/overflow/drain, full with simultaneous
//   read and write across the pointer wrap, an end-to-end run through a
//   modelled DFC sender with 2-cycle forward and return delays, and reset
//   with data stored.
module tb_dfc_rx_fifo;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checkCount = 0;
    int   passCount = 0;
    int   totalWords = 0;

    always #5 clk = ~clk;

    dfc_rx_fifo_if #(.width(8)) link ();

    dfc_rx_fifo #(
        .width     (8),
        .depth     (8),
        .threshold (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .link  (link)
    );

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Called at a falling edge: drive inputs for the next rising edge and
    // return at the following falling edge, where outputs are stable.
    task automatic applyStimulus(input logic vld, input logic [7:0] data,
                                 input logic drdy);
        link.c_vld  = vld;
        link.c_data = data;
        link.p_drdy = drdy;
        @(negedge clk);
    endtask

    // Sender model: registered send decision fed by a 2-stage return delay
    // of c_fc_n, followed by a 2-stage forward delay to c_vld. All model
    // registers are advanced once per cycle at the falling edge using the
    // values they would have captured at the preceding rising edge.
    task automatic runEndToEnd(input logic [31:0] srdyPat,
                               input logic [31:0] drdyPat, input string tag);
        int         sent = 0;
        int         received = 0;
        int         orderErrors = 0;
        logic       ret0, ret1, sVld, fwd0, fwd1, prevFc, sbit;
        logic [7:0] sData, fwd0D, fwd1D, nextSeq, expSeq;
        ret0 = link.c_fc_n;
        ret1 = link.c_fc_n;
        prevFc = link.c_fc_n;
        sVld = 1'b0; fwd0 = 1'b0; fwd1 = 1'b0;
        sData = '0; fwd0D = '0; fwd1D = '0;
        nextSeq = '0; expSeq = '0;
        for (int cyc = 0; cyc < 840; cyc++) begin
            sbit = (cyc < 800) ? srdyPat[cyc % 32] : 1'b0;
            fwd1  = fwd0;
            fwd1D = fwd0D;
            fwd0  = sVld;
            fwd0D = sData;
            sVld  = ret1 & sbit;
            if (sVld) begin
                sData = nextSeq;
                nextSeq++;
                sent++;
            end
            ret1 = ret0;
            ret0 = prevFc;
            link.c_vld  = fwd1;
            link.c_data = fwd1D;
            link.p_drdy = (cyc < 800) ? drdyPat[cyc % 32] : 1'b1;
            if (link.p_srdy && link.p_drdy) begin
                if (link.p_data !== expSeq) begin
                    orderErrors++;
                end
                expSeq++;
                received++;
            end
            prevFc = link.c_fc_n;
            @(negedge clk);
        end
        link.c_vld = 1'b0;
        checkOutput({tag, "_order_errors"}, orderErrors, 0);
        checkOutput({tag, "_received_vs_sent"}, received, sent);
        checkOutput({tag, "_empty_after"}, {31'd0, link.p_srdy}, 0);
        totalWords += received;
    endtask

    initial begin
        link.c_vld  = 1'b0;
        link.c_data = '0;
        link.p_drdy = 1'b0;

        // Reset held for three cycles, then released
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_srdy", {31'd0, link.p_srdy}, 0);
        checkOutput("rst_fc_n", {31'd0, link.c_fc_n}, 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_fc_n", {31'd0, link.c_fc_n}, 1);
        checkOutput("post_rst_srdy", {31'd0, link.p_srdy}, 0);

        // Single word passes through with one cycle of latency
        applyStimulus(1'b1, 8'h3C, 1'b1);
        checkOutput("single_srdy", {31'd0, link.p_srdy}, 1);
        checkOutput("single_data", {24'd0, link.p_data}, 32'h3C);
        checkOutput("single_fc_n", {31'd0, link.c_fc_n}, 1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("single_empty", {31'd0, link.p_srdy}, 0);
        checkOutput("single_fc_n_after", {31'd0, link.c_fc_n}, 1);

        // Nine words into a stalled FIFO; the ninth is dropped
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0);
            checkOutput($sformatf("fill_fc_n_%0d", i), {31'd0, link.c_fc_n},
                        ((i + 1) <= 1) ? 1 : 0);
        end
        checkOutput("fill_head", {24'd0, link.p_data}, 32'h00);
        for (int j = 0; j < 8; j++) begin
            checkOutput($sformatf("drain_srdy_%0d", j), {31'd0, link.p_srdy}, 1);
            checkOutput($sformatf("drain_data_%0d", j), {24'd0, link.p_data}, j);
            checkOutput($sformatf("drain_fc_n_%0d", j), {31'd0, link.c_fc_n},
                        ((8 - j) <= 1) ? 1 : 0);
            applyStimulus(1'b0, 8'h00, 1'b1);
        end
        checkOutput("drain_empty", {31'd0, link.p_srdy}, 0);
        checkOutput("drain_fc_n", {31'd0, link.c_fc_n}, 1);

        // Full FIFO with write and read in the same cycle, across the wrap
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 8'(8'h10 + i), 1'b0);
        end
        checkOutput("full_fc_n", {31'd0, link.c_fc_n}, 0);
        checkOutput("full_head", {24'd0, link.p_data}, 32'h10);
        applyStimulus(1'b1, 8'h18, 1'b1);
        checkOutput("full_rw_srdy", {31'd0, link.p_srdy}, 1);
        checkOutput("full_rw_head", {24'd0, link.p_data}, 32'h11);
        checkOutput("full_rw_fc_n", {31'd0, link.c_fc_n}, 0);
        for (int j = 0; j < 8; j++) begin
            checkOutput($sformatf("wrap_data_%0d", j), {24'd0, link.p_data}, 32'h11 + j);
            applyStimulus(1'b0, 8'h00, 1'b1);
        end
        checkOutput("wrap_empty", {31'd0, link.p_srdy}, 0);

        // End to end through the delayed flow-control loop
        link.p_drdy = 1'b0;
        runEndToEnd(32'hFFFFFFFF, 32'hFFFFFFFF, "e2e_ff");
        runEndToEnd(32'h5A5A5A5A, 32'hA5A5A5A5, "e2e_5a");
        runEndToEnd(32'hFDFDFDFD, 32'h03030303, "e2e_fd");
        runEndToEnd(32'h11111111, 32'hEEEEEEEE, "e2e_11");
        checkOutput("e2e_total_ge_1000", {31'd0, (totalWords >= 1000)}, 1);

        // Reset with five words stored; none of them may reappear
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'(8'hA0 + i), 1'b0);
        end
        checkOutput("pre_rst_srdy", {31'd0, link.p_srdy}, 1);
        reset = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("mid_rst_srdy", {31'd0, link.p_srdy}, 0);
        checkOutput("mid_rst_fc_n", {31'd0, link.c_fc_n}, 0);
        reset = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("after_rst_srdy", {31'd0, link.p_srdy}, 0);
        checkOutput("after_rst_fc_n", {31'd0, link.c_fc_n}, 1);
        applyStimulus(1'b1, 8'h55, 1'b0);
        checkOutput("after_rst_new_head", {24'd0, link.p_data}, 32'h55);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("after_rst_final_empty", {31'd0, link.p_srdy}, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
